// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, write-entry type and helpers for the register file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_CNT_W    = 16;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] data;
    } wr_entry_t;

    // One-hot of the destination register, empty when the entry holds nothing.
    function automatic logic [RF_NUM_REGS-1:0] dest_onehot(input wr_entry_t e);
        logic [RF_NUM_REGS-1:0] oh;
        oh = '0;
        if (e.valid) oh[e.dest] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wr_slot.sv
// One-entry holding buffer for a single write requester.
module regfile_wr_slot
    import regfile_write_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RF_ADDR_W-1:0] in_dest,
    input  logic [RF_DATA_W-1:0] in_data,
    input  logic                 drain,
    output wr_entry_t            entry
);

    // A buffer being drained this cycle can take a new entry on the same edge.
    assign in_ready = !entry.valid || drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else if (in_valid && in_ready) begin
            entry.valid <= 1'b1;
            entry.dest  <= in_dest;
            entry.data  <= in_data;
        end else if (drain) begin
            entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between two buffered requesters,
// keeping per-register pending bits and a committed-write counter.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_W-1:0]    req0_dest,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_W-1:0]    req1_dest,
    input  logic [DATA_W-1:0]    req1_data,
    output logic [ADDR_W-1:0]    rf_dest_sel,
    output logic [DATA_W-1:0]    rf_d,
    output logic                 rf_load_en,
    output logic [2**ADDR_W-1:0] pending,
    output logic [CNT_W-1:0]     commit_count
);

    wr_entry_t slot0;
    wr_entry_t slot1;
    logic      grant0;
    logic      grant1;
    logic      grant_any;
    logic      accept0;
    logic      accept1;
    logic      persist0;
    logic      persist1;
    logic      age_valid;
    logic      age_old;
    logic      rr;

    regfile_wr_slot u_slot0 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (req0_valid),
        .in_ready (req0_ready),
        .in_dest  (req0_dest),
        .in_data  (req0_data),
        .drain    (grant0),
        .entry    (slot0)
    );

    regfile_wr_slot u_slot1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (req1_valid),
        .in_ready (req1_ready),
        .in_dest  (req1_dest),
        .in_data  (req1_data),
        .drain    (grant1),
        .entry    (slot1)
    );

    // Older entry wins so same-destination writes commit in arrival order;
    // entries that arrived together fall back to the round-robin pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!hold) begin
            if (slot0.valid && slot1.valid) begin
                if (age_valid) grant0 = (age_old == P0);
                else           grant0 = (rr == P0);
                grant1 = !grant0;
            end else begin
                grant0 = slot0.valid;
                grant1 = slot1.valid;
            end
        end
    end

    assign grant_any = grant0 || grant1;
    assign accept0   = req0_valid && req0_ready;
    assign accept1   = req1_valid && req1_ready;
    assign persist0  = slot0.valid && !grant0;
    assign persist1  = slot1.valid && !grant1;

    always_comb begin
        rf_dest_sel = '0;
        rf_d        = '0;
        if (grant0) begin
            rf_dest_sel = slot0.dest;
            rf_d        = slot0.data;
        end else if (grant1) begin
            rf_dest_sel = slot1.dest;
            rf_d        = slot1.data;
        end
    end

    assign rf_load_en = grant_any;
    assign pending    = dest_onehot(slot0) | dest_onehot(slot1);

    // Age is only meaningful while both buffers are full; an entry that stays
    // put while the other buffer refills becomes the older one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_valid    <= 1'b0;
            age_old      <= P0;
            rr           <= P0;
            commit_count <= '0;
        end else begin
            if (persist0 && accept1) begin
                age_valid <= 1'b1;
                age_old   <= P0;
            end else if (persist1 && accept0) begin
                age_valid <= 1'b1;
                age_old   <= P1;
            end else if (!(persist0 && persist1)) begin
                age_valid <= 1'b0;
            end
            if (grant_any && slot0.valid && slot1.valid && !age_valid) rr <= ~rr;
            if (grant_any) commit_count <= commit_count + CNT_W'(1);
        end
    end

endmodule
